// File: rtl/mio_pkg.sv
// Shared definitions for the MIO port arbiter: FSM state encoding and
// default parameter values.
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10,
        DONE  = 2'b11
    } mio_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_TIMEOUT  = 16;

endpackage

// File: rtl/mio_prio_pick.sv
// Combinational owner selection: CPU (m0) wins unless master 1 has been
// starved, in which case master 1 wins a tie.
module mio_prio_pick (
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       starve,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (m1_req && (!m0_req || starve)) begin
            pick = 2'b10;
        end else if (m0_req) begin
            pick = 2'b01;
        end
    end

endmodule

// File: rtl/mio_arbiter.sv
// Two-master arbiter for the shared MIO slave port. One FSM owns the slave
// request, the per-master completion pulses and the starvation counter.
module mio_arbiter
    import mio_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        grant,
    output logic [1:0]        fsm_state
);

    // Handshake: a master holds req (with stable we/addr/wdata) until it sees
    // its one-cycle ready; the slave holds nothing, it pulses s_ready once
    // while s_req is high and s_rdata is valid in that same cycle.

    mio_state_e  state;
    logic [3:0]  wait_cnt;
    logic [7:0]  tmo_cnt;
    logic [1:0]  pick;
    logic        starve;

    assign starve    = (wait_cnt == 4'(MAX_WAIT));
    assign fsm_state = state;

    mio_prio_pick u_pick (
        .m0_req (m0_req),
        .m1_req (m1_req),
        .starve (starve),
        .pick   (pick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
            m0_ready <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ready <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
            s_req    <= 1'b0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            grant    <= 2'b00;
        end else begin
            m0_ready <= 1'b0;
            m0_err   <= 1'b0;
            m1_ready <= 1'b0;
            m1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick[0]) begin
                        state   <= BUSY0;
                        s_req   <= 1'b1;
                        s_we    <= m0_we;
                        s_addr  <= m0_addr;
                        s_wdata <= m0_wdata;
                        grant   <= 2'b01;
                        tmo_cnt <= '0;
                        if (m1_req && !starve) begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end else if (pick[1]) begin
                        state    <= BUSY1;
                        s_req    <= 1'b1;
                        s_we     <= m1_we;
                        s_addr   <= m1_addr;
                        s_wdata  <= m1_wdata;
                        grant    <= 2'b10;
                        tmo_cnt  <= '0;
                        wait_cnt <= '0;
                    end
                end
                BUSY0, BUSY1: begin
                    if (s_ready || tmo_cnt == 8'(TIMEOUT - 1)) begin
                        state <= DONE;
                        s_req <= 1'b0;
                        grant <= 2'b00;
                        if (state == BUSY0) begin
                            m0_ready <= 1'b1;
                            m0_err   <= !s_ready;
                            if (s_ready && !s_we) m0_rdata <= s_rdata;
                        end else begin
                            m1_ready <= 1'b1;
                            m1_err   <= !s_ready;
                            if (s_ready && !s_we) m1_rdata <= s_rdata;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed self-checking bench for mio_arbiter with default parameters
// (MAX_WAIT = 4, TIMEOUT = 16).
module tb_mio_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  grant, fsm_state;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_grant [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                   2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    mio_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #12;
        checks++;
        if ({m0_ready, m0_err, m1_ready, m1_err, s_req, s_we, grant, fsm_state} !== 10'b0) begin
            errors++;
            $display("FAIL reset_bits: got %b want 0", {m0_ready, m0_err, m1_ready, m1_err, s_req, s_we, grant, fsm_state});
        end
        checks++;
        if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {s_addr, s_wdata, m0_rdata, m1_rdata});
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++;
        if (fsm_state !== 2'b00 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got state %b s_req %b want 00/0", fsm_state, s_req);
        end
    endtask

    task automatic test_m0_read();
        @(negedge clk); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
        @(negedge clk);
        checks++;
        if (s_req !== 1'b1 || grant !== 2'b01 || s_addr !== 32'h10 || s_we !== 1'b0 || m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL m0_read_issue: got s_req %b grant %b addr %h we %b want 1/01/10/0", s_req, grant, s_addr, s_we);
        end
        @(negedge clk);
        checks++;
        if (s_req !== 1'b1 || m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL m0_read_hold: got s_req %b ready %b want 1/0", s_req, m0_ready);
        end
        s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (m0_ready !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL m0_read_done: got ready %b err %b rdata %h want 1/0/deadbeef", m0_ready, m0_err, m0_rdata);
        end
        checks++;
        if (m1_ready !== 1'b0 || m1_err !== 1'b0 || m1_rdata !== 32'h0 || grant !== 2'b00 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL m0_read_others: got m1 %b/%b/%h grant %b s_req %b want idle", m1_ready, m1_err, m1_rdata, grant, s_req);
        end
        m0_req = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_ready !== 1'b0 || fsm_state !== 2'b00) begin
            errors++;
            $display("FAIL m0_read_pulse: got ready %b state %b want 0/00", m0_ready, fsm_state);
        end
    endtask

    task automatic test_starvation();
        bit found;
        @(negedge clk); m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        s_ready = 1'b1; s_rdata = 32'hA5A5_0001;
        for (int i = 0; i < 10; i++) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (grant !== 2'b00) begin
                    found = 1'b1;
                    break;
                end
            end
            checks++;
            if (!found || grant !== exp_grant[i]) begin
                errors++;
                $display("FAIL grant_order[%0d]: got %b want %b", i, grant, exp_grant[i]);
            end
            if (i == 3) begin
                checks++;
                if (dut.wait_cnt !== 4'd4) begin
                    errors++;
                    $display("FAIL wait_cnt_sat: got %0d want 4", dut.wait_cnt);
                end
            end
            if (i == 4) begin
                checks++;
                if (dut.wait_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL wait_cnt_clear: got %0d want 0", dut.wait_cnt);
                end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL m1_read_done: got ready %b rdata %h want 1/a5a50001", m1_ready, m1_rdata);
        end
        s_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_m1_write_hold();
        @(negedge clk); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'h1234;
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_we !== 1'b1 || s_addr !== 32'h8000_0000 || s_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL m1_write_issue: got grant %b we %b addr %h wdata %h", grant, s_we, s_addr, s_wdata);
        end
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h44; m1_addr = 32'hDEAD_0000; m1_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_addr !== 32'h8000_0000 || s_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL m1_write_latched: got grant %b addr %h wdata %h want 10/80000000/1234", grant, s_addr, s_wdata);
        end
        s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_rdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL m1_write_done: got m1_ready %b m0_ready %b m1_rdata %h want 1/0/a5a50001", m1_ready, m0_ready, m1_rdata);
        end
        m1_req = 1'b0; m1_we = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b01 || s_addr !== 32'h44) begin
            errors++;
            $display("FAIL m0_after_m1: got grant %b addr %h want 01/44", grant, s_addr);
        end
        s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL m0_after_m1_done: got ready %b rdata %h want 1/0badf00d", m0_ready, m0_rdata);
        end
        m0_req = 1'b0; s_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat;
        lat = 0;
        @(negedge clk); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (m0_ready) break;
        end
        checks++;
        if (lat !== 17 || m0_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles err %b want 17/1", lat, m0_err);
        end
        checks++;
        if (m0_rdata !== 32'h0BAD_F00D || s_req !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL timeout_state: got rdata %h s_req %b grant %b want 0badf00d/0/00", m0_rdata, s_req, grant);
        end
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_ready !== 1'b0 || m0_err !== 1'b0 || fsm_state !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: got ready %b err %b state %b want 0/0/00", m0_ready, m0_err, fsm_state);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); m0_req = 1'b1; m0_addr = 32'h30;
        @(negedge clk);
        checks++;
        if (s_req !== 1'b1 || grant !== 2'b01) begin
            errors++;
            $display("FAIL mid_reset_busy: got s_req %b grant %b want 1/01", s_req, grant);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (s_req !== 1'b0 || grant !== 2'b00 || fsm_state !== 2'b00 || s_addr !== 32'h0 || m0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got s_req %b grant %b state %b addr %h rdata %h want 0", s_req, grant, fsm_state, s_addr, m0_rdata);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (m0_ready !== 1'b0 || m0_err !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_ready: got ready %b err %b want 0/0", m0_ready, m0_err);
            end
        end
        reset = 1'b1; m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_ready !== 1'b0 || fsm_state !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_release: got ready %b state %b want 0/00", m0_ready, fsm_state);
        end
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h50;
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_addr !== 32'h50) begin
            errors++;
            $display("FAIL fresh_m1_issue: got grant %b addr %h want 10/50", grant, s_addr);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_600D;
        @(negedge clk);
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'h600D) begin
            errors++;
            $display("FAIL fresh_m1_done: got ready %b rdata %h want 1/600d", m1_ready, m1_rdata);
        end
        m1_req = 1'b0; s_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sready_idle();
        @(negedge clk); s_ready = 1'b1; s_rdata = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (fsm_state !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || s_req !== 1'b0 ||
                m0_rdata !== 32'h0 || m1_rdata !== 32'h600D) begin
                errors++;
                $display("FAIL sready_idle[%0d]: got state %b rdy %b%b s_req %b rdata %h/%h", k, fsm_state, m0_ready, m1_ready, s_req, m0_rdata, m1_rdata);
            end
        end
        s_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_starvation();
        test_m1_write_hold();
        test_timeout();
        test_reset_mid();
        test_sready_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
